mod13_seq_checker: RTL and testbench
====================================

MOD13_SEQ_CHECKER -- requirements
Module: mod13_seq_checker

Interface
REQ-001 Parameter LOCK_CNT, default 3: consecutive correct transitions required to enter LOCKED; legal range 1..7.
REQ-002 Parameter WRAP_W, default 8: width of wrap_cnt.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 mrst  input  1  master reset; asynchronous, active-low.
REQ-005 q_in  input  4  count value from the upstream mod-13 counter (legal 0..12); that counter updates on the falling edge, so q_in is stable at the rising edge.
REQ-006 clr  input  1  synchronous clear of err_sticky and wrap_cnt, active-high.
REQ-007 locked  output  1  high while the FSM is in LOCKED.
REQ-008 err_pulse  output  1  one-cycle pulse on a detected sequence error.
REQ-009 err_sticky  output  1  set by err_pulse; held until clr or reset.
REQ-010 wrap_pulse  output  1  one-cycle pulse on each valid 12->0 transition.
REQ-011 wrap_cnt  output  WRAP_W  number of valid wraps, saturating.

Function
REQ-012 Expected next value: prev+1 when prev<12; 0 when prev=12.
REQ-013 A transition is correct iff the sample is legal (<=12) and equals the expected next value of the previous registered sample.
REQ-014 FSM states: IDLE, SYNC, LOCKED, ERROR; 2-bit encoding.
REQ-015 IDLE: capture q_in into prev; go to SYNC; no outputs asserted.
REQ-016 SYNC: correct transition increments run counter; when run reaches LOCK_CNT, go to LOCKED on the same edge; incorrect transition clears run and stays in SYNC, no error flagged.
REQ-017 LOCKED: correct transition stays in LOCKED; incorrect transition goes to ERROR and asserts err_pulse in the cycle after that edge.
REQ-018 ERROR: lasts exactly one cycle; next edge captures q_in into prev, clears run, goes to SYNC.
REQ-019 prev is updated with q_in on every rising edge in every state, including on illegal values.
REQ-020 Latency: all registered outputs change on the rising edge following the sampled transition; outputs are registered, not combinational.
REQ-021 wrap_pulse asserts only in LOCKED for a correct 12->0 transition; wrap_cnt increments by 1 at the same edge.
REQ-022 wrap_cnt saturates at 2^WRAP_W-1; no wrap-around.
REQ-023 clr coincident with a wrap: clear wins, wrap_cnt=0; clr coincident with an error: err_sticky ends set, error wins.
REQ-024 An upstream reset mid-sequence (q_in jumping to 0 from a value other than 12) is an incorrect transition and is handled as in REQ-016/REQ-017.
REQ-025 Values 13..15 on q_in are always incorrect, both as current sample and as predecessor.

Reset
REQ-026 mrst low asynchronously forces: state=IDLE, prev=0, run=0, locked=0, err_pulse=0, err_sticky=0, wrap_pulse=0, wrap_cnt=0.
REQ-027 Reset release takes effect at the first rising edge with mrst high; that edge executes IDLE.
REQ-028 Reset asserted mid-operation discards all state, including any pending pulse.

Configuration
REQ-029 Macro MOD13_WRAP_CNT_EN defined: wrap counter and wrap_pulse implemented per REQ-021..REQ-023.
REQ-030 Macro MOD13_WRAP_CNT_EN undefined: wrap_pulse and wrap_cnt tied to 0, no wrap counter flops, port list unchanged, all other behaviour identical.

Verification
REQ-031 Reset, then q_in 0,1,2,3 on successive edges -> locked=1 one cycle after the edge that samples 3 (LOCK_CNT=3), err_sticky=0.
REQ-032 Locked, q_in ...11,12,0 -> one-cycle wrap_pulse after the edge that samples 0, wrap_cnt 0->1; with macro undefined, wrap_pulse=0 and wrap_cnt=0.
REQ-033 Locked at 5, inject 7 -> err_pulse one cycle, err_sticky=1, locked=0; then 8,9,10,11 -> locked=1 again, err_sticky stays 1.
REQ-034 Locked, inject 13 -> err_pulse=1; clr=1 for one cycle -> err_sticky=0, wrap_cnt=0.
REQ-035 WRAP_W=2, 5 full wraps while locked -> wrap_cnt=3 and holds; mrst pulsed low 2 ns mid-count -> all outputs 0 immediately, locked again after LOCK_CNT correct transitions.

Source files
------------

// File: rtl/mod13_seq_checker.sv
// Sequence checker for an upstream mod-13 counter: locks onto a clean
// 0..12 count, flags breaks in the sequence and optionally counts wraps.
//
// Optional feature macro: MOD13_WRAP_CNT_EN (wrap_pulse / wrap_cnt logic).
//
// Ports:
//   clk        - single clock, all state updates on the rising edge
//   mrst       - master reset, asynchronous, active-low
//   q_in[3:0]  - sampled count from the upstream counter (legal 0..12)
//   clr        - synchronous clear of err_sticky and wrap_cnt
//   locked     - high while the checker is in LOCKED
//   err_pulse  - one-cycle pulse on a sequence error while locked
//   err_sticky - set by an error, held until clr or reset
//   wrap_pulse - one-cycle pulse on each valid 12->0 while locked
//   wrap_cnt   - saturating count of valid wraps
module mod13_seq_checker #(
    parameter int LOCK_CNT = 3,
    parameter int WRAP_W   = 8
) (
    input  logic              clk,
    input  logic              mrst,
    input  logic [3:0]        q_in,
    input  logic              clr,
    output logic              locked,
    output logic              err_pulse,
    output logic              err_sticky,
    output logic              wrap_pulse,
    output logic [WRAP_W-1:0] wrap_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SYNC   = 2'b01,
        LOCKED = 2'b10,
        ERROR  = 2'b11
    } state_t;

    localparam logic [2:0] LOCK_RUN = 3'(LOCK_CNT);

    state_t     state;
    logic [3:0] prev;
    logic [2:0] run;
    logic [3:0] exp_next;
    logic       correct;

    // An illegal predecessor (13..15) has no valid successor, so it
    // must be rejected explicitly rather than through prev+1.
    always_comb begin
        exp_next = (prev == 4'd12) ? 4'd0 : prev + 4'd1;
        correct  = (q_in <= 4'd12) && (prev <= 4'd12)
                && (q_in == exp_next);
    end

    always_ff @(posedge clk or negedge mrst) begin
        if (!mrst) begin
            state      <= IDLE;
            prev       <= 4'd0;
            run        <= 3'd0;
            locked     <= 1'b0;
            err_pulse  <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            prev      <= q_in;
            err_pulse <= 1'b0;
            if (clr)
                err_sticky <= 1'b0;
            unique case (state)
                IDLE: begin
                    state  <= SYNC;
                    run    <= 3'd0;
                    locked <= 1'b0;
                end
                SYNC: begin
                    if (correct) begin
                        if (run + 3'd1 == LOCK_RUN) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                            run    <= 3'd0;
                        end else begin
                            run <= run + 3'd1;
                        end
                    end else begin
                        run <= 3'd0;
                    end
                end
                LOCKED: begin
                    // Assigned after the clr term so a coincident
                    // error leaves err_sticky set.
                    if (!correct) begin
                        state      <= ERROR;
                        locked     <= 1'b0;
                        err_pulse  <= 1'b1;
                        err_sticky <= 1'b1;
                    end
                end
                ERROR: begin
                    state <= SYNC;
                    run   <= 3'd0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef MOD13_WRAP_CNT_EN
    logic wrap_hit;

    always_comb begin
        wrap_hit = (state == LOCKED) && correct && (prev == 4'd12);
    end

    always_ff @(posedge clk or negedge mrst) begin
        if (!mrst) begin
            wrap_pulse <= 1'b0;
            wrap_cnt   <= '0;
        end else begin
            wrap_pulse <= wrap_hit;
            // clr takes priority over a coincident wrap.
            if (clr)
                wrap_cnt <= '0;
            else if (wrap_hit && (wrap_cnt != {WRAP_W{1'b1}}))
                wrap_cnt <= wrap_cnt + 1'b1;
        end
    end
`else
    assign wrap_pulse = 1'b0;
    assign wrap_cnt   = '0;
`endif

endmodule

// File: tb/tb_mod13_seq_checker.sv
// Directed testbench for mod13_seq_checker (LOCK_CNT=3, WRAP_W=2).
// Expectations follow the build's MOD13_WRAP_CNT_EN setting.
module tb_mod13_seq_checker;

    logic       clk;
    logic       mrst;
    logic [3:0] q_in;
    logic       clr;
    logic       locked;
    logic       err_pulse;
    logic       err_sticky;
    logic       wrap_pulse;
    logic [1:0] wrap_cnt;

    int n_chk;
    int n_fail;

`ifdef MOD13_WRAP_CNT_EN
    localparam bit WE = 1'b1;
`else
    localparam bit WE = 1'b0;
`endif

    mod13_seq_checker #(.LOCK_CNT(3), .WRAP_W(2)) dut (
        .clk        (clk),
        .mrst       (mrst),
        .q_in       (q_in),
        .clr        (clr),
        .locked     (locked),
        .err_pulse  (err_pulse),
        .err_sticky (err_sticky),
        .wrap_pulse (wrap_pulse),
        .wrap_cnt   (wrap_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge, outputs sampled 1 ns after rise.
    task automatic drive(input logic [3:0] v);
        @(negedge clk);
        q_in = v;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        mrst = 1'b0;
        clr  = 1'b0;
        @(posedge clk);
        #2;
        mrst = 1'b1;
    endtask

    task automatic test_reset();
        mrst = 1'b1;
        q_in = 4'd0;
        clr  = 1'b0;
        #1;
        mrst = 1'b0;
        #12;
        n_chk++;
        if ({locked, err_pulse, err_sticky, wrap_pulse} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags got=%b exp=0000",
                     {locked, err_pulse, err_sticky, wrap_pulse});
        end
        n_chk++;
        if (wrap_cnt !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_wrap_cnt got=%0d exp=0", wrap_cnt);
        end
        @(posedge clk);
        #2;
        mrst = 1'b1;
    endtask

    // 0 is captured by IDLE, 1,2,3 are the three correct transitions.
    task automatic test_lock();
        for (int v = 0; v < 3; v++) begin
            drive(4'(v));
            n_chk++;
            if (locked !== 1'b0) begin
                n_fail++;
                $display("FAIL lock_early v=%0d got=%b exp=0", v, locked);
            end
        end
        drive(4'd3);
        n_chk++;
        if ({locked, err_sticky, err_pulse} !== 3'b100) begin
            n_fail++;
            $display("FAIL lock3 got=%b exp=100",
                     {locked, err_sticky, err_pulse});
        end
    endtask

    task automatic test_wrap();
        for (int v = 4; v <= 12; v++) begin
            drive(4'(v));
            n_chk++;
            if ({locked, wrap_pulse} !== 2'b10) begin
                n_fail++;
                $display("FAIL wrap_pre v=%0d got=%b exp=10", v,
                         {locked, wrap_pulse});
            end
        end
        drive(4'd0);
        n_chk++;
        if (wrap_pulse !== WE || wrap_cnt !== {1'b0, WE}) begin
            n_fail++;
            $display("FAIL wrap_hit pulse=%b cnt=%0d exp=%b/%0d",
                     wrap_pulse, wrap_cnt, WE, WE);
        end
        drive(4'd1);
        n_chk++;
        if (wrap_pulse !== 1'b0 || wrap_cnt !== {1'b0, WE}
            || locked !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_after pulse=%b cnt=%0d lk=%b",
                     wrap_pulse, wrap_cnt, locked);
        end
    endtask

    // Locked at 5, jump to 7, then resync on 8,9,10,11.
    task automatic test_error();
        for (int v = 2; v <= 5; v++) drive(4'(v));
        drive(4'd7);
        n_chk++;
        if ({err_pulse, err_sticky, locked} !== 3'b110) begin
            n_fail++;
            $display("FAIL err_skip got=%b exp=110",
                     {err_pulse, err_sticky, locked});
        end
        drive(4'd8);
        n_chk++;
        if ({err_pulse, err_sticky, locked} !== 3'b010) begin
            n_fail++;
            $display("FAIL err_one_cycle got=%b exp=010",
                     {err_pulse, err_sticky, locked});
        end
        drive(4'd9);
        drive(4'd10);
        n_chk++;
        if (locked !== 1'b0) begin
            n_fail++;
            $display("FAIL err_resync_early got=%b exp=0", locked);
        end
        drive(4'd11);
        n_chk++;
        if ({locked, err_sticky} !== 2'b11) begin
            n_fail++;
            $display("FAIL err_relock got=%b exp=11", {locked, err_sticky});
        end
    endtask

    task automatic test_illegal_clr();
        drive(4'd12);
        drive(4'd13);
        n_chk++;
        if ({err_pulse, locked} !== 2'b10) begin
            n_fail++;
            $display("FAIL illegal13 got=%b exp=10", {err_pulse, locked});
        end
        @(negedge clk);
        clr  = 1'b1;
        q_in = 4'd0;
        @(posedge clk);
        #1;
        clr = 1'b0;
        n_chk++;
        if ({err_sticky, err_pulse} !== 2'b00 || wrap_cnt !== 2'd0) begin
            n_fail++;
            $display("FAIL clr got=%b cnt=%0d exp=00/0",
                     {err_sticky, err_pulse}, wrap_cnt);
        end
        // Now in SYNC with prev=0: relock, then error coincident with clr.
        drive(4'd1);
        drive(4'd2);
        drive(4'd3);
        @(negedge clk);
        clr  = 1'b1;
        q_in = 4'd9;
        @(posedge clk);
        #1;
        clr = 1'b0;
        n_chk++;
        if ({err_pulse, err_sticky, locked} !== 3'b110) begin
            n_fail++;
            $display("FAIL clr_vs_err got=%b exp=110",
                     {err_pulse, err_sticky, locked});
        end
    endtask

    // SYNC-phase rules: no error flagging, run cleared on a break,
    // illegal predecessor rejected, upstream reset while locked.
    task automatic test_sync_rules();
        drive(4'd10);
        drive(4'd11);
        drive(4'd12);
        drive(4'd5);
        n_chk++;
        if ({err_pulse, locked} !== 2'b00) begin
            n_fail++;
            $display("FAIL sync_break got=%b exp=00", {err_pulse, locked});
        end
        drive(4'd6);
        drive(4'd7);
        n_chk++;
        if (locked !== 1'b0) begin
            n_fail++;
            $display("FAIL sync_run_clr got=%b exp=0", locked);
        end
        drive(4'd8);
        n_chk++;
        if (locked !== 1'b1) begin
            n_fail++;
            $display("FAIL sync_relock got=%b exp=1", locked);
        end
        drive(4'd0);
        n_chk++;
        if ({err_pulse, locked} !== 2'b10) begin
            n_fail++;
            $display("FAIL upstream_rst got=%b exp=10", {err_pulse, locked});
        end
        drive(4'd13);
        drive(4'd0);
        drive(4'd1);
        drive(4'd2);
        n_chk++;
        if (locked !== 1'b0) begin
            n_fail++;
            $display("FAIL pred13 got=%b exp=0", locked);
        end
        drive(4'd3);
        n_chk++;
        if ({locked, err_pulse} !== 2'b10) begin
            n_fail++;
            $display("FAIL pred13_lock got=%b exp=10", {locked, err_pulse});
        end
    endtask

    task automatic test_saturate_reset();
        logic [1:0] exp_c;
        reset_dut();
        for (int v = 0; v <= 3; v++) drive(4'(v));
        for (int k = 1; k <= 5; k++) begin
            for (int v = (k == 1) ? 4 : 1; v <= 12; v++) drive(4'(v));
            drive(4'd0);
            exp_c = WE ? ((k > 3) ? 2'd3 : 2'(k)) : 2'd0;
            n_chk++;
            if (wrap_cnt !== exp_c || wrap_pulse !== WE) begin
                n_fail++;
                $display("FAIL sat k=%0d cnt=%0d pulse=%b exp=%0d/%b",
                         k, wrap_cnt, wrap_pulse, exp_c, WE);
            end
        end
        #1;
        mrst = 1'b0;
        #1;
        n_chk++;
        if ({locked, err_pulse, err_sticky, wrap_pulse} !== 4'b0000
            || wrap_cnt !== 2'd0) begin
            n_fail++;
            $display("FAIL async_rst got=%b cnt=%0d exp=0000/0",
                     {locked, err_pulse, err_sticky, wrap_pulse}, wrap_cnt);
        end
        #1;
        mrst = 1'b1;
        drive(4'd5);
        drive(4'd6);
        drive(4'd7);
        n_chk++;
        if (locked !== 1'b0) begin
            n_fail++;
            $display("FAIL post_rst_early got=%b exp=0", locked);
        end
        drive(4'd8);
        n_chk++;
        if (locked !== 1'b1 || wrap_cnt !== 2'd0) begin
            n_fail++;
            $display("FAIL post_rst_lock lk=%b cnt=%0d exp=1/0",
                     locked, wrap_cnt);
        end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        test_reset();
        test_lock();
        test_wrap();
        test_error();
        test_illegal_clr();
        test_sync_rules();
        test_saturate_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
